cs2fifod: RTL and testbench
===========================

Name: cs2fifod

Overview:
- Transmit-side counterpart of the command parser. On a start request from the console FSM, it snapshots the device status registers and serialises them as a framed response into the data FIFO (fifod, write side, sys_clk domain).
- It also reports the frame length so the FIFO-to-MAC stage can size the UDP payload (eth_tx_len).
- It sits between the console/status logic and fifod, mirroring fifoc-to-registers in the opposite direction.

Parameters:
- NUM_REG, 16: number of 8-bit status registers carried per frame (1..64).
- HEAD0, 8'h55: first header byte.
- HEAD1, 8'hAA: second header byte.
- TIMEOUT, 1024: consecutive fifod_full cycles tolerated before the frame is aborted.

Ports:
- clk  in  1  system clock (sys_clk).
- rst  in  1  asynchronous, active-high reset.
- fs  in  1  start request; level, held high by the master until fd is seen.
- fd  out  1  done; high from frame completion or abort until fs falls.
- err  out  1  abort flag; valid while fd is high.
- kind_dev  in  8  device kind byte.
- stat_data  in  8*NUM_REG  status registers; reg k is at [8k+7:8k].
- fifod_full  in  1  fifod full flag.
- fifod_txen  out  1  fifod write enable.
- fifod_txd  out  8  fifod write data.
- data_len  out  12  bytes in the current/last frame.

Behaviour:
- Reset: fd=0, err=0, fifod_txen=0, fifod_txd=0, seq=0, data_len=0, state IDLE. Reset mid-frame abandons the frame; the partial bytes stay in fifod and the downstream FIFO reset clears them.
- Frame byte order:
  - 0: HEAD0
  - 1: HEAD1
  - 2: kind_dev
  - 3: seq
  - 4: NUM_REG[7:0]
  - 5 .. 4+NUM_REG: reg0 .. reg(NUM_REG-1)
  - optional checksum byte (see Optional Feature).
- data_len = 5+NUM_REG (+1 with checksum). It is registered in LOAD and held until the next LOAD.
- States:
  - IDLE: fd=0, err=0. fs=1 -> LOAD.
  - LOAD (1 cycle): latch stat_data, kind_dev and data_len; idx=0; timeout counter=0 -> SEND. Inputs changing after LOAD do not affect the frame.
  - SEND:
    - Each cycle with fifod_full=0: fifod_txen=1, fifod_txd=byte[idx], idx++, timeout counter cleared.
    - When fifod_full=1: fifod_txen=0, idx holds, timeout counter++.
    - After the last byte is written -> DONE.
    - Timeout counter reaching TIMEOUT -> ERR.
  - DONE: fd=1, seq<=seq+1 once on entry (8-bit, 255 wraps to 0). fs=0 -> IDLE.
  - ERR: fd=1, err=1, seq not incremented. fs=0 -> IDLE.
- Output registration: fifod_txen and fifod_txd are registered. A byte is written on the cycle after fifod_full is sampled low. fifod_full is assumed to include one cycle of almost-full margin.
- Throughput: one byte per clock with no back-pressure. Frame latency from fs rising to fd rising is data_len+2 cycles.
- fs dropping before fd: the frame runs to completion and fd pulses for one cycle, then the block returns to IDLE.
- fs held high after returning to IDLE: a new frame starts only after fs has been seen low.
- No writes occur outside SEND.

Optional Feature:
- Macro: CS2FIFOD_SUM_EN.
- Defined: one trailing byte equal to the 8-bit modulo-256 sum of bytes 2 .. 4+NUM_REG. data_len includes it.
- Undefined: no checksum byte; data_len = 5+NUM_REG; the accumulator logic is not synthesised.

Decomposition:
- Shared package cs_pkg holds:
  - state encoding as one-hot 8-bit localparams (IDLE, LOAD, SEND, DONE, ERR);
  - header byte constants;
  - the frame byte-offset constants (OFS_KIND=2, OFS_SEQ=3, OFS_LEN=4, OFS_DATA=5).
- One natural sub-module: cs2fifod_mux, a combinational byte selector from idx and the snapshot to the next frame byte. Everything else stays in cs2fifod.

Test Plan:
- NUM_REG=16, reg k=k+1, kind_dev=8'h6B, fifod_full=0, fs raised: exactly 21 writes 55 AA 6B 00 10 01..10 on consecutive cycles; fd rises at cycle 23; data_len=21.
- Same frame with fifod_full high for 5 cycles mid-payload: byte sequence unchanged, no duplicate or lost bytes, fd 5 cycles later, err=0.
- fifod_full held high for TIMEOUT cycles during SEND: writes stop, fd=1 and err=1, seq unchanged; after fs falls the next frame carries seq=00.
- 257 back-to-back frames: the seq byte runs 00..FF then 00.
- Assert rst mid-SEND at byte 9: all outputs are 0 next cycle, seq=0; the next fs produces a complete frame from HEAD0.
- With CS2FIFOD_SUM_EN and regs all 8'h01, kind_dev=8'h6B: the 22nd byte equals (6B+00+10+10) mod 256 = 8'h8B, and data_len=22.

Source files
------------

// File: rtl/cs_pkg.sv
// cs2fifod shared constants: one-hot state codes, header bytes
// and frame byte offsets.
package cs_pkg;

  localparam logic [7:0] ST_IDLE = 8'h01;
  localparam logic [7:0] ST_LOAD = 8'h02;
  localparam logic [7:0] ST_SEND = 8'h04;
  localparam logic [7:0] ST_DONE = 8'h08;
  localparam logic [7:0] ST_ERR  = 8'h10;

  localparam logic [7:0] CS_HEAD0 = 8'h55;
  localparam logic [7:0] CS_HEAD1 = 8'hAA;

  localparam int OFS_HEAD0 = 0;
  localparam int OFS_HEAD1 = 1;
  localparam int OFS_KIND  = 2;
  localparam int OFS_SEQ   = 3;
  localparam int OFS_LEN   = 4;
  localparam int OFS_DATA  = 5;

  function automatic int frame_len(input int num_reg, input bit sum_en);
    return OFS_DATA + num_reg + (sum_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/cs2fifod_if.sv
// Console/status side and fifod write side of cs2fifod.
// slave is the cs2fifod view, master the surrounding logic.
interface cs2fifod_if #(
  parameter int NUM_REG = 16
);
  logic                   fs;
  logic                   fd;
  logic                   err;
  logic [7:0]             kind_dev;
  logic [8*NUM_REG-1:0]   stat_data;
  logic                   fifod_full;
  logic                   fifod_txen;
  logic [7:0]             fifod_txd;
  logic [11:0]            data_len;

  modport slave (
    input  fs, kind_dev, stat_data, fifod_full,
    output fd, err, fifod_txen, fifod_txd, data_len
  );

  modport master (
    output fs, kind_dev, stat_data, fifod_full,
    input  fd, err, fifod_txen, fifod_txd, data_len
  );
endinterface

// File: rtl/cs2fifod_mux.sv
// Frame byte selector: maps the byte index onto header, snapshot
// fields, status registers or the trailing checksum.
module cs2fifod_mux
  import cs_pkg::*;
#(
  parameter int         NUM_REG = 16,
  parameter logic [7:0] HEAD0   = CS_HEAD0,
  parameter logic [7:0] HEAD1   = CS_HEAD1
)(
  input  logic [6:0]           idx,
  input  logic [8*NUM_REG-1:0] snap,
  input  logic [7:0]           kind,
  input  logic [7:0]           seq,
  input  logic [7:0]           sum,
  output logic [7:0]           nbyte
);

  always_comb begin
    nbyte = sum;
    unique case (idx)
      7'(OFS_HEAD0): nbyte = HEAD0;
      7'(OFS_HEAD1): nbyte = HEAD1;
      7'(OFS_KIND):  nbyte = kind;
      7'(OFS_SEQ):   nbyte = seq;
      7'(OFS_LEN):   nbyte = 8'(NUM_REG);
      default: begin
        for (int k = 0; k < NUM_REG; k++) begin
          if (idx == 7'(OFS_DATA + k)) nbyte = snap[8*k +: 8];
        end
      end
    endcase
  end

endmodule

// File: rtl/cs2fifod.sv
// Status snapshot serialiser into fifod (sys_clk domain).
// Define CS2FIFOD_SUM_EN to append a modulo-256 checksum byte.
module cs2fifod
  import cs_pkg::*;
#(
  parameter int         NUM_REG = 16,
  parameter logic [7:0] HEAD0   = CS_HEAD0,
  parameter logic [7:0] HEAD1   = CS_HEAD1,
  parameter int         TIMEOUT = 1024
)(
  input logic     clk,
  input logic     rst,
  cs2fifod_if.slave bus
);

`ifdef CS2FIFOD_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  localparam int             FLEN = frame_len(NUM_REG, SUM_EN);
  localparam logic [6:0]     LAST = 7'(FLEN - 1);
  localparam int             TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

  logic [7:0]           state;
  logic [6:0]           idx;
  logic [TW-1:0]        tmo;
  logic [8*NUM_REG-1:0] snap;
  logic [7:0]           kind;
  logic [7:0]           seq;
  logic [7:0]           sum;
  logic [7:0]           nbyte;

  cs2fifod_mux #(
    .NUM_REG (NUM_REG),
    .HEAD0   (HEAD0),
    .HEAD1   (HEAD1)
  ) u_mux (
    .idx   (idx),
    .snap  (snap),
    .kind  (kind),
    .seq   (seq),
    .sum   (sum),
    .nbyte (nbyte)
  );

`ifdef CS2FIFOD_SUM_EN
  // accumulate kind..last register as they are written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 8'h00;
    end else if (state == ST_LOAD) begin
      sum <= 8'h00;
    end else if (state == ST_SEND && !bus.fifod_full &&
                 idx >= 7'(OFS_KIND) && idx < LAST) begin
      sum <= sum + nbyte;
    end
  end
`else
  assign sum = 8'h00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      tmo            <= '0;
      snap           <= '0;
      kind           <= '0;
      seq            <= '0;
      bus.fd         <= 1'b0;
      bus.err        <= 1'b0;
      bus.fifod_txen <= 1'b0;
      bus.fifod_txd  <= 8'h00;
      bus.data_len   <= 12'h000;
    end else begin
      bus.fifod_txen <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          bus.fd  <= 1'b0;
          bus.err <= 1'b0;
          if (bus.fs) state <= ST_LOAD;
        end
        (state == ST_LOAD): begin
          snap         <= bus.stat_data;
          kind         <= bus.kind_dev;
          bus.data_len <= 12'(FLEN);
          idx          <= '0;
          tmo          <= '0;
          state        <= ST_SEND;
        end
        (state == ST_SEND): begin
          if (!bus.fifod_full) begin
            bus.fifod_txen <= 1'b1;
            bus.fifod_txd  <= nbyte;
            idx            <= idx + 7'd1;
            tmo            <= '0;
            if (idx == LAST) begin
              bus.fd <= 1'b1;
              seq    <= seq + 8'd1;
              state  <= ST_DONE;
            end
          end else if (tmo == TMAX) begin
            bus.fd  <= 1'b1;
            bus.err <= 1'b1;
            state   <= ST_ERR;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        (state == ST_DONE),
        (state == ST_ERR): begin
          if (!bus.fs) begin
            bus.fd  <= 1'b0;
            bus.err <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs2fifod.sv
// Randomised directed bench for cs2fifod against a frame-level
// reference model (byte queue, sequence counter, latency).
module tb_cs2fifod;

  localparam int NR  = 16;
  localparam int TMO = 1024;
`ifdef CS2FIFOD_SUM_EN
  localparam int FL = NR + 6;
`else
  localparam int FL = NR + 5;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs2fifod_if #(.NUM_REG(NR)) bus();

  cs2fifod #(.NUM_REG(NR), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         ncnt   = 0;
  int         fd_at  = -1;
  int         n0;
  int         lat;
  logic       err_s;
  logic       fd2;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  logic [7:0] regs[NR];
  logic [7:0] kind;
  logic [7:0] mseq = 8'h00;

  always @(negedge clk) begin
    ncnt++;
    if (bus.fifod_txen === 1'b1) cap.push_back(bus.fifod_txd);
    if (bus.fd === 1'b1 && fd_at < 0) fd_at = ncnt;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, want);
    end
  endtask

  task automatic build();
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(kind);
    exp_q.push_back(mseq);
    exp_q.push_back(8'(NR));
    for (int k = 0; k < NR; k++) exp_q.push_back(regs[k]);
`ifdef CS2FIFOD_SUM_EN
    s = 8'h00;
    for (int i = 2; i < exp_q.size(); i++) s = s + exp_q[i];
    exp_q.push_back(s);
`else
    s = 8'h00;
`endif
    for (int k = 0; k < NR; k++) bus.stat_data[8*k +: 8] = regs[k];
    bus.kind_dev = kind;
  endtask

  task automatic rand_regs();
    for (int k = 0; k < NR; k++) regs[k] = 8'($urandom);
    kind = 8'($urandom);
  endtask

  task automatic frame(input int stall_at, input int stall_len,
                       input int drop_at);
    build();
    fd_at = -1;
    cap.delete();
    @(negedge clk); #1;
    n0 = ncnt;
    bus.fs = 1'b1;
    for (int i = 0; i < 3000 && fd_at < 0; i++) begin
      @(negedge clk); #1;
      if (ncnt - n0 == 2) begin
        bus.kind_dev = 8'($urandom);
        for (int k = 0; k < NR; k++) bus.stat_data[8*k +: 8] = 8'($urandom);
      end
      if (ncnt - n0 == stall_at) bus.fifod_full = 1'b1;
      if (ncnt - n0 == stall_at + stall_len) bus.fifod_full = 1'b0;
      if (ncnt - n0 == drop_at) bus.fs = 1'b0;
    end
    lat   = (fd_at < 0) ? -1 : fd_at - n0;
    err_s = bus.err;
    @(negedge clk); #1;
    fd2 = bus.fd;
    bus.fs = 1'b0;
    bus.fifod_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_bytes(input string tag, input int n);
    for (int i = 0; i < n && i < cap.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  task automatic good_frame(input string tag, input int stall_at,
                            input int stall_len, input int drop_at);
    int extra;
    extra = (stall_at >= 2 && stall_at <= FL) ? stall_len : 0;
    frame(stall_at, stall_len, drop_at);
    chk({tag, "_cnt"}, 32'(cap.size()), 32'(FL));
    cmp_bytes(tag, FL);
    chk({tag, "_lat"}, 32'(lat), 32'(FL + 2 + extra));
    chk({tag, "_err"}, 32'(err_s), 32'd0);
    chk({tag, "_fd2"}, 32'(fd2), (drop_at >= 0) ? 32'd0 : 32'd1);
    chk({tag, "_dlen"}, 32'(bus.data_len), 32'(FL));
    mseq = mseq + 8'd1;
  endtask

  initial begin
    rst = 1'b1;
    bus.fs = 1'b0;
    bus.fifod_full = 1'b0;
    bus.kind_dev = 8'h00;
    bus.stat_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_fd", 32'(bus.fd), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_txen", 32'(bus.fifod_txen), 32'd0);
    chk("rst_txd", 32'(bus.fifod_txd), 32'd0);
    chk("rst_dlen", 32'(bus.data_len), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // abort: full from after edge 6 until the timeout fires
    for (int k = 0; k < NR; k++) regs[k] = 8'(k + 1);
    kind = 8'h6B;
    frame(6, 5000, -1);
    chk("tmo_lat", 32'(lat), 32'(6 + TMO));
    chk("tmo_err", 32'(err_s), 32'd1);
    chk("tmo_cnt", 32'(cap.size()), 32'd4);
    cmp_bytes("tmo", 4);

    good_frame("base", -100, 0, -1);
    chk("base_seq", 32'(cap.size() > 3 ? cap[3] : 8'hEE), 32'h00);
    good_frame("stall", 10, 5, -1);

    for (int f = 0; f < 10; f++) begin
      rand_regs();
      good_frame($sformatf("rnd%0d", f), $urandom_range(2, FL),
                 $urandom_range(0, 8),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(1, FL) : -1);
    end

    for (int f = 0; f < 257; f++) begin
      rand_regs();
      good_frame($sformatf("b2b%0d", f), -100, 0, -1);
    end

    // reset in the middle of SEND after the 9th byte
    rand_regs();
    build();
    cap.delete();
    @(negedge clk); #1;
    bus.fs = 1'b1;
    for (int i = 0; i < 100 && cap.size() < 9; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_cnt", 32'(cap.size()), 32'd9);
    rst = 1'b1;
    #1;
    chk("mid_fd", 32'(bus.fd), 32'd0);
    chk("mid_err", 32'(bus.err), 32'd0);
    chk("mid_txen", 32'(bus.fifod_txen), 32'd0);
    chk("mid_txd", 32'(bus.fifod_txd), 32'd0);
    chk("mid_dlen", 32'(bus.data_len), 32'd0);
    bus.fs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mseq = 8'h00;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NR; k++) regs[k] = 8'h01;
    kind = 8'h6B;
    good_frame("post", -100, 0, -1);
    chk("post_seq", 32'(cap.size() > 3 ? cap[3] : 8'hEE), 32'h00);
`ifdef CS2FIFOD_SUM_EN
    chk("sum_byte", 32'(cap.size() == 22 ? cap[21] : 8'hEE), 32'h8B);
    chk("sum_dlen", 32'(bus.data_len), 32'd22);
`else
    chk("nosum_dlen", 32'(bus.data_len), 32'd21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
